display_timings: RTL

- Parameterised raster timing generator that produces screen coordinates, sync, data-enable and frame/line markers for one pixel clock domain.
- Sits directly upstream of the sprite engines and colour logic. Its outputs also feed the TMDS/DVI generator.
- Replaces fixed-mode timing modules: one block, with the mode selected by parameters (1080p default).

---
 rtl/display_timing_pkg.sv | 33 +++
 rtl/display_timings.sv | 112 +++++++++++
 2 files changed

// File: rtl/display_timing_pkg.sv
// Video mode descriptions shared by the raster timing generator and its users.
// Each mode carries porch, sync and polarity values for both axes.
package display_timing_pkg;

  typedef struct packed {
    int unsigned h_res;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    logic        h_pol;
    int unsigned v_res;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        v_pol;
  } mode_t;

  localparam mode_t MODE_1080P60 = '{h_res: 1920, h_fp: 88, h_sync: 44, h_bp: 148, h_pol: 1'b1,
                                     v_res: 1080, v_fp: 4,  v_sync: 5,  v_bp: 36,  v_pol: 1'b1};
  localparam mode_t MODE_720P60  = '{h_res: 1280, h_fp: 110, h_sync: 40, h_bp: 220, h_pol: 1'b1,
                                     v_res: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,  v_pol: 1'b1};
  localparam mode_t MODE_480P60  = '{h_res: 640, h_fp: 16, h_sync: 96, h_bp: 48, h_pol: 1'b0,
                                     v_res: 480, v_fp: 10, v_sync: 2,  v_bp: 33, v_pol: 1'b0};

  function automatic int unsigned mode_h_total(mode_t m);
    return m.h_res + m.h_fp + m.h_sync + m.h_bp;
  endfunction

  function automatic int unsigned mode_v_total(mode_t m);
    return m.v_res + m.v_fp + m.v_sync + m.v_bp;
  endfunction

endpackage

// File: rtl/display_timings.sv
// Raster timing generator: pixel/line counters plus sync, de and marker decode.
// Decode runs on next-state coordinates so every output is registered with zero skew.
module display_timings
  import display_timing_pkg::*;
#(
  parameter int unsigned CORDW  = 12,
  parameter int unsigned H_RES  = MODE_1080P60.h_res,
  parameter int unsigned H_FP   = MODE_1080P60.h_fp,
  parameter int unsigned H_SYNC = MODE_1080P60.h_sync,
  parameter int unsigned H_BP   = MODE_1080P60.h_bp,
  parameter int unsigned V_RES  = MODE_1080P60.v_res,
  parameter int unsigned V_FP   = MODE_1080P60.v_fp,
  parameter int unsigned V_SYNC = MODE_1080P60.v_sync,
  parameter int unsigned V_BP   = MODE_1080P60.v_bp,
  parameter logic        H_POL  = MODE_1080P60.h_pol,
  parameter logic        V_POL  = MODE_1080P60.v_pol,
  parameter int unsigned FRAMEW = 16
) (
  input  logic              clk_pix,
  input  logic              rst_n,
  output logic [CORDW-1:0]  sx,
  output logic [CORDW-1:0]  sy,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              line,
  output logic              frame,
  output logic [FRAMEW-1:0] frame_count
);

  localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > (2 ** CORDW) || V_TOTAL > (2 ** CORDW)) begin : g_cordw_chk
      $error("CORDW too narrow for H_TOTAL-1 / V_TOTAL-1");
    end
    if (H_SYNC < 1 || V_SYNC < 1) begin : g_sync_chk
      $error("sync widths must be at least one");
    end
  endgenerate

  localparam logic [CORDW-1:0] H_MAX = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_MAX = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_LO = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_HI = CORDW'(H_RES + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] VS_LO = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_HI = CORDW'(V_RES + V_FP + V_SYNC - 1);

  logic [CORDW-1:0]  sx_q, sx_d, sy_q, sy_d;
  logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic              line_q, line_d, frame_q, frame_d;
  logic [FRAMEW-1:0] fc_q, fc_d;
  logic              first_q, first_d;

  always_comb begin
    sx_d    = sx_q + 1'b1;
    sy_d    = sy_q;
    if (sx_q == H_MAX) begin
      sx_d = '0;
      sy_d = (sy_q == V_MAX) ? '0 : sy_q + 1'b1;
    end
    de_d    = (sx_d < H_ACT) && (sy_d < V_ACT);
    hs_d    = (sx_d >= HS_LO && sx_d <= HS_HI) ? H_POL : ~H_POL;
    vs_d    = (sy_d >= VS_LO && sy_d <= VS_HI) ? V_POL : ~V_POL;
    line_d  = (sx_d == '0);
    frame_d = (sx_d == '0) && (sy_d == '0);
    fc_d    = fc_q;
    first_d = first_q;
    // The frame that starts out of reset is not a completed frame.
    if (frame_d) begin
      if (first_q) first_d = 1'b0;
      else         fc_d    = fc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      sx_q    <= H_MAX;
      sy_q    <= V_MAX;
      hs_q    <= ~H_POL;
      vs_q    <= ~V_POL;
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      fc_q    <= '0;
      first_q <= 1'b1;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      fc_q    <= fc_d;
      first_q <= first_d;
    end
  end

  assign sx          = sx_q;
  assign sy          = sy_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign line        = line_q;
  assign frame       = frame_q;
  assign frame_count = fc_q;

endmodule
